ysyx_24080014_mem_arbiter: RTL and testbench

//  Shares the single-port physical-memory access unit between IFU (read-only) and LSU (read/write).

---
 rtl/ysyx_24080014_mem_arbiter.sv | 117 +++++++++++
 tb/tb_ysyx_24080014_mem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080014_mem_arbiter.sv
// ysyx_24080014_mem_arbiter: shares one memory access unit between IFU (read) and LSU (read/write)
// Ports: clk, rst (sync, active-low)
//   IFU:  i_ifu_req_valid/o_ifu_req_ready, i_ifu_raddr, o_ifu_rsp_valid, o_ifu_rdata
//   LSU:  i_lsu_req_valid/o_lsu_req_ready, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
//         o_lsu_rsp_valid, o_lsu_rdata
//   MEM:  o_mem_ren, o_mem_wen, o_mem_raddr, o_mem_waddr, o_mem_din, o_mem_wmask, i_mem_ready, i_mem_dout
//   o_arb_err: sticky read-timeout flag
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise LSU has fixed priority.
module ysyx_24080014_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ifu_req_valid,
  output logic              o_ifu_req_ready,
  input  logic [ADDR_W-1:0] i_ifu_raddr,
  output logic              o_ifu_rsp_valid,
  output logic [DATA_W-1:0] o_ifu_rdata,
  input  logic              i_lsu_req_valid,
  output logic              o_lsu_req_ready,
  input  logic              i_lsu_wen,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [DATA_W-1:0] i_lsu_wdata,
  input  logic [7:0]        i_lsu_wmask,
  output logic              o_lsu_rsp_valid,
  output logic [DATA_W-1:0] o_lsu_rdata,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_raddr,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [DATA_W-1:0] o_mem_din,
  output logic [7:0]        o_mem_wmask,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic              o_arb_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            r_state, w_next;
  logic              r_lsu, r_wen, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_ifu_rdata, r_lsu_rdata;
  logic [7:0]        r_wmask;
  logic [CW-1:0]     r_cnt;
  logic              w_gnt_lsu, w_idle, w_hs, w_done;
  logic [DATA_W-1:0] w_rd;
`ifdef ARB_ROUND_ROBIN_EN
  // remembers who won the previous handshake; reset to IFU so LSU wins the first tie
  logic r_last_lsu;
  assign w_gnt_lsu = i_lsu_req_valid & (!i_ifu_req_valid | !r_last_lsu);
  always_ff @(posedge clk)
    if (!rst) r_last_lsu <= 1'b0;
    else if (w_hs) r_last_lsu <= w_gnt_lsu;
`else
  assign w_gnt_lsu = i_lsu_req_valid;
`endif
  assign w_idle = r_state == IDLE;
  assign w_hs   = w_idle & (i_ifu_req_valid | i_lsu_req_valid);
  // writes finish after one WAIT cycle; reads on mem_ready or on the TIMEOUT-th WAIT cycle
  assign w_done = r_wen | i_mem_ready | (r_cnt == CW'(TIMEOUT - 1));
  assign w_rd   = r_wen ? '0 : i_mem_ready ? i_mem_dout : DATA_W'(32'hDEADBEEF);
  always_ff @(posedge clk)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_hs ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = w_done ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      r_lsu       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_cnt       <= '0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_hs) begin
        r_lsu   <= w_gnt_lsu;
        r_wen   <= w_gnt_lsu & i_lsu_wen;
        r_addr  <= w_gnt_lsu ? i_lsu_addr : i_ifu_raddr;
        r_wdata <= i_lsu_wdata;
        r_wmask <= i_lsu_wmask;
      end
      r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      if (r_state == WAIT && w_done) begin
        if (r_lsu) r_lsu_rdata <= w_rd;
        else r_ifu_rdata <= w_rd;
        if (!r_wen && !i_mem_ready) r_err <= 1'b1;
      end
    end
  always_comb begin
    o_ifu_req_ready = w_idle & i_ifu_req_valid & !w_gnt_lsu;
    o_lsu_req_ready = w_idle & w_gnt_lsu;
    o_mem_ren       = (r_state == ISSUE) & !r_wen;
    o_mem_wen       = (r_state == ISSUE) & r_wen;
    o_mem_raddr     = (!w_idle & !r_wen) ? r_addr : '0;
    o_mem_waddr     = (!w_idle & r_wen) ? r_addr : '0;
    o_mem_din       = (!w_idle & r_wen) ? r_wdata : '0;
    o_mem_wmask     = (!w_idle & r_wen) ? r_wmask : '0;
    o_ifu_rsp_valid = (r_state == RESP) & !r_lsu;
    o_lsu_rsp_valid = (r_state == RESP) & r_lsu;
    o_ifu_rdata     = r_ifu_rdata;
    o_lsu_rdata     = r_lsu_rdata;
    o_arb_err       = r_err;
  end
endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// tb_ysyx_24080014_mem_arbiter: directed self-checking bench for the memory arbiter
module tb_ysyx_24080014_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        i_ifu_req_valid, o_ifu_req_ready, o_ifu_rsp_valid;
  logic [31:0] i_ifu_raddr, o_ifu_rdata;
  logic        i_lsu_req_valid, o_lsu_req_ready, i_lsu_wen, o_lsu_rsp_valid;
  logic [31:0] i_lsu_addr, i_lsu_wdata, o_lsu_rdata;
  logic [7:0]  i_lsu_wmask, o_mem_wmask;
  logic        o_mem_ren, o_mem_wen, i_mem_ready, o_arb_err;
  logic [31:0] o_mem_raddr, o_mem_waddr, o_mem_din, i_mem_dout;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ysyx_24080014_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_ifu_req_valid(i_ifu_req_valid), .o_ifu_req_ready(o_ifu_req_ready), .i_ifu_raddr(i_ifu_raddr),
    .o_ifu_rsp_valid(o_ifu_rsp_valid), .o_ifu_rdata(o_ifu_rdata),
    .i_lsu_req_valid(i_lsu_req_valid), .o_lsu_req_ready(o_lsu_req_ready), .i_lsu_wen(i_lsu_wen),
    .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata), .i_lsu_wmask(i_lsu_wmask),
    .o_lsu_rsp_valid(o_lsu_rsp_valid), .o_lsu_rdata(o_lsu_rdata),
    .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_mem_raddr(o_mem_raddr), .o_mem_waddr(o_mem_waddr),
    .o_mem_din(o_mem_din), .o_mem_wmask(o_mem_wmask), .i_mem_ready(i_mem_ready), .i_mem_dout(i_mem_dout),
    .o_arb_err(o_arb_err)
  );
  task automatic idle_inputs();
    i_ifu_req_valid = 1'b0; i_ifu_raddr = '0;
    i_lsu_req_valid = 1'b0; i_lsu_wen = 1'b0; i_lsu_addr = '0; i_lsu_wdata = '0; i_lsu_wmask = '0;
    i_mem_ready = 1'b0; i_mem_dout = '0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (o_mem_ren !== 1'b0 || o_mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_mem_pulses got ren=%b wen=%b exp 0 0", o_mem_ren, o_mem_wen); end
    n_chk++; if (o_ifu_rsp_valid !== 1'b0 || o_lsu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got ifu=%b lsu=%b exp 0 0", o_ifu_rsp_valid, o_lsu_rsp_valid); end
    n_chk++; if (o_ifu_rdata !== 32'h0 || o_lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got ifu=%h lsu=%h exp 0 0", o_ifu_rdata, o_lsu_rdata); end
    n_chk++; if (o_mem_raddr !== 32'h0 || o_mem_waddr !== 32'h0 || o_mem_din !== 32'h0 || o_mem_wmask !== 8'h0) begin n_fail++; $display("FAIL reset_mem_bus got %h %h %h %h exp all 0", o_mem_raddr, o_mem_waddr, o_mem_din, o_mem_wmask); end
    n_chk++; if (o_arb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", o_arb_err); end
    @(posedge clk); #1 rst = 1'b1;
  endtask
  task automatic test_ifu_read();
    @(posedge clk); #1 i_ifu_req_valid = 1'b1; i_ifu_raddr = 32'h80000000;
    @(negedge clk);
    n_chk++; if (o_ifu_req_ready !== 1'b1 || o_lsu_req_ready !== 1'b0) begin n_fail++; $display("FAIL ifu_ready got ifu=%b lsu=%b exp 1 0", o_ifu_req_ready, o_lsu_req_ready); end
    @(posedge clk); #1 i_ifu_req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (o_mem_ren !== 1'b1 || o_mem_wen !== 1'b0) begin n_fail++; $display("FAIL ifu_issue got ren=%b wen=%b exp 1 0", o_mem_ren, o_mem_wen); end
    n_chk++; if (o_mem_raddr !== 32'h80000000) begin n_fail++; $display("FAIL ifu_raddr got %h exp 80000000", o_mem_raddr); end
    @(posedge clk); #1 i_mem_ready = 1'b1; i_mem_dout = 32'h00000413;
    @(negedge clk);
    n_chk++; if (o_ifu_rsp_valid !== 1'b0 || o_mem_ren !== 1'b0) begin n_fail++; $display("FAIL ifu_wait got rsp=%b ren=%b exp 0 0", o_ifu_rsp_valid, o_mem_ren); end
    @(posedge clk); #1 i_mem_ready = 1'b0; i_mem_dout = 32'h0;
    @(negedge clk);
    n_chk++; if (o_ifu_rsp_valid !== 1'b1 || o_lsu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_rsp got ifu=%b lsu=%b exp 1 0", o_ifu_rsp_valid, o_lsu_rsp_valid); end
    n_chk++; if (o_ifu_rdata !== 32'h00000413) begin n_fail++; $display("FAIL ifu_rdata got %h exp 00000413", o_ifu_rdata); end
    n_chk++; if (o_mem_raddr !== 32'h80000000) begin n_fail++; $display("FAIL ifu_raddr_hold got %h exp 80000000", o_mem_raddr); end
    @(negedge clk);
    n_chk++; if (o_ifu_rsp_valid !== 1'b0 || o_ifu_rdata !== 32'h00000413) begin n_fail++; $display("FAIL ifu_after got rsp=%b data=%h exp 0 00000413", o_ifu_rsp_valid, o_ifu_rdata); end
  endtask
  task automatic test_lsu_load();
    @(posedge clk); #1 i_lsu_req_valid = 1'b1; i_lsu_wen = 1'b0; i_lsu_addr = 32'h80002000;
    @(negedge clk);
    n_chk++; if (o_lsu_req_ready !== 1'b1 || o_ifu_req_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready got lsu=%b ifu=%b exp 1 0", o_lsu_req_ready, o_ifu_req_ready); end
    @(posedge clk); #1 i_lsu_req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (o_mem_ren !== 1'b1 || o_mem_raddr !== 32'h80002000) begin n_fail++; $display("FAIL load_issue got ren=%b addr=%h exp 1 80002000", o_mem_ren, o_mem_raddr); end
    @(posedge clk); #1 i_mem_ready = 1'b1; i_mem_dout = 32'hCAFEF00D;
    @(posedge clk); #1 i_mem_ready = 1'b0; i_mem_dout = 32'h0;
    @(negedge clk);
    n_chk++; if (o_lsu_rsp_valid !== 1'b1 || o_ifu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL load_rsp got lsu=%b ifu=%b exp 1 0", o_lsu_rsp_valid, o_ifu_rsp_valid); end
    n_chk++; if (o_lsu_rdata !== 32'hCAFEF00D || o_ifu_rdata !== 32'h00000413) begin n_fail++; $display("FAIL load_rdata got lsu=%h ifu=%h exp cafef00d 00000413", o_lsu_rdata, o_ifu_rdata); end
  endtask
  task automatic test_lsu_store();
    @(posedge clk); #1 i_lsu_req_valid = 1'b1; i_lsu_wen = 1'b1; i_lsu_addr = 32'h80001000; i_lsu_wdata = 32'h12345678; i_lsu_wmask = 8'h0F;
    @(negedge clk);
    n_chk++; if (o_lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_ready got %b exp 1", o_lsu_req_ready); end
    @(posedge clk); #1 i_lsu_req_valid = 1'b0; i_lsu_wen = 1'b0; i_lsu_wdata = '0; i_lsu_wmask = '0; i_mem_dout = 32'hFFFFFFFF;
    @(negedge clk);
    n_chk++; if (o_mem_wen !== 1'b1 || o_mem_ren !== 1'b0) begin n_fail++; $display("FAIL store_issue got wen=%b ren=%b exp 1 0", o_mem_wen, o_mem_ren); end
    n_chk++; if (o_mem_waddr !== 32'h80001000 || o_mem_din !== 32'h12345678 || o_mem_wmask !== 8'h0F) begin n_fail++; $display("FAIL store_bus got %h %h %h exp 80001000 12345678 0f", o_mem_waddr, o_mem_din, o_mem_wmask); end
    @(negedge clk);
    n_chk++; if (o_mem_wen !== 1'b0 || o_lsu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL store_wait got wen=%b rsp=%b exp 0 0", o_mem_wen, o_lsu_rsp_valid); end
    @(negedge clk);
    n_chk++; if (o_lsu_rsp_valid !== 1'b1 || o_ifu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL store_rsp got lsu=%b ifu=%b exp 1 0", o_lsu_rsp_valid, o_ifu_rsp_valid); end
    n_chk++; if (o_lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL store_rdata got %h exp 0", o_lsu_rdata); end
    @(posedge clk); #1 i_mem_dout = 32'h0;
  endtask
  task automatic test_back_to_back();
`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] exp_lsu = 3'b101;
`else
    logic [2:0] exp_lsu = 3'b111;
`endif
    do_reset();
    i_mem_ready = 1'b1; i_mem_dout = 32'h00000011;
    i_ifu_req_valid = 1'b1; i_ifu_raddr = 32'h80000100;
    i_lsu_req_valid = 1'b1; i_lsu_wen = 1'b0; i_lsu_addr = 32'h80000200;
    for (int i = 0; i < 3; i++) begin
      int w = 0;
      @(negedge clk);
      while (!(o_ifu_req_ready || o_lsu_req_ready) && w < 10) begin @(negedge clk); w++; end
      n_chk++; if (!(o_ifu_req_ready || o_lsu_req_ready)) begin n_fail++; $display("FAIL b2b_grant_%0d got no ready within 10 cycles exp a grant", i); end
      n_chk++; if (o_lsu_req_ready !== exp_lsu[i] || o_ifu_req_ready !== !exp_lsu[i]) begin n_fail++; $display("FAIL b2b_winner_%0d got lsu=%b ifu=%b exp lsu=%b", i, o_lsu_req_ready, o_ifu_req_ready, exp_lsu[i]); end
    end
    @(posedge clk); #1 i_ifu_req_valid = 1'b0; i_lsu_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    i_mem_ready = 1'b0; i_mem_dout = 32'h0;
    n_chk++; if (o_lsu_rdata !== 32'h00000011) begin n_fail++; $display("FAIL b2b_lsu_rdata got %h exp 00000011", o_lsu_rdata); end
  endtask
  task automatic test_timeout();
    int n = 0;
    @(posedge clk); #1 i_ifu_req_valid = 1'b1; i_ifu_raddr = 32'h80003000;
    @(negedge clk);
    n_chk++; if (o_ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready got %b exp 1", o_ifu_req_ready); end
    @(posedge clk); #1 i_ifu_req_valid = 1'b0;
    do begin @(negedge clk); n++; end while (!o_ifu_rsp_valid && n < 40);
    n_chk++; if (n !== 18) begin n_fail++; $display("FAIL to_latency got %0d cycles exp 18", n); end
    n_chk++; if (o_ifu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_rdata got %h exp deadbeef", o_ifu_rdata); end
    n_chk++; if (o_arb_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b exp 1", o_arb_err); end
    @(posedge clk); #1 i_ifu_req_valid = 1'b1; i_ifu_raddr = 32'h80000004; i_mem_ready = 1'b1; i_mem_dout = 32'h00005555;
    @(posedge clk); #1 i_ifu_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    i_mem_ready = 1'b0; i_mem_dout = 32'h0;
    n_chk++; if (o_ifu_rdata !== 32'h00005555 || o_arb_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky got data=%h err=%b exp 00005555 1", o_ifu_rdata, o_arb_err); end
  endtask
  task automatic test_reset_in_wait();
    int hits = 0;
    @(posedge clk); #1 i_ifu_req_valid = 1'b1; i_ifu_raddr = 32'h80004000;
    @(posedge clk); #1 i_ifu_req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1; i_mem_ready = 1'b1; i_mem_dout = 32'h77777777;
    @(negedge clk);
    n_chk++; if (o_ifu_rsp_valid !== 1'b0 || o_mem_ren !== 1'b0 || o_mem_raddr !== 32'h0) begin n_fail++; $display("FAIL rw_outputs got rsp=%b ren=%b addr=%h exp 0 0 0", o_ifu_rsp_valid, o_mem_ren, o_mem_raddr); end
    n_chk++; if (o_arb_err !== 1'b0 || o_ifu_rdata !== 32'h0) begin n_fail++; $display("FAIL rw_cleared got err=%b data=%h exp 0 0", o_arb_err, o_ifu_rdata); end
    repeat (3) begin @(negedge clk); if (o_ifu_rsp_valid || o_lsu_rsp_valid) hits++; end
    n_chk++; if (hits !== 0) begin n_fail++; $display("FAIL rw_late_rsp got %0d pulses exp 0", hits); end
    i_mem_ready = 1'b0; i_mem_dout = 32'h0; i_ifu_req_valid = 1'b1;
    #1;
    n_chk++; if (o_ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_idle got ready=%b exp 1", o_ifu_req_ready); end
    i_ifu_req_valid = 1'b0;
  endtask
  task automatic test_spurious();
    int hits = 0;
    @(posedge clk); #1 i_mem_ready = 1'b1; i_mem_dout = 32'h00000BAD;
    repeat (3) begin @(negedge clk); if (o_ifu_rsp_valid || o_lsu_rsp_valid || o_mem_ren || o_mem_wen) hits++; end
    n_chk++; if (hits !== 0) begin n_fail++; $display("FAIL spur_activity got %0d cycles exp 0", hits); end
    i_lsu_req_valid = 1'b1;
    #1;
    n_chk++; if (o_lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL spur_idle got ready=%b exp 1", o_lsu_req_ready); end
    idle_inputs();
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_ifu_read();
    test_lsu_load();
    test_lsu_store();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
